// File: rtl/centroid_calc.sv
// Per-frame centroid engine: accumulates matched pixel coordinates, then divides the sums
// by the match count with a pair of parallel restoring dividers at end of frame.
module centroid_calc #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned MIN_PIXELS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iPix_Val,
    input  logic       iMatch,
    input  logic [9:0] iX,
    input  logic [8:0] iY,
    input  logic       iFrame_End,
    output logic       oCent_Val,
    output logic [9:0] oX_Cent,
    output logic [8:0] oY_Cent,
    output logic       oBusy,
    output logic       oDrop
);

    typedef enum logic [1:0] {StIdle, StDiv, StOut} state_t;

    localparam logic [28:0] XMax = 29'(H_RES - 1);
    localparam logic [28:0] YMax = 29'(V_RES - 1);
    localparam logic [18:0] MinCnt = 19'(MIN_PIXELS);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [28:0] r_sum_x;
    logic [28:0] r_sum_y;
    logic [18:0] r_cnt;
    logic        r_sat;

    logic [18:0] r_div;
    logic [28:0] r_qx;
    logic [28:0] r_qy;
    logic [18:0] r_rx;
    logic [18:0] r_ry;
    logic [4:0]  r_step;
    logic [9:0]  r_x_cent;
    logic [8:0]  r_y_cent;
    logic        r_drop;

    logic        w_hit;
    logic [29:0] w_sx_sum;
    logic [29:0] w_sy_sum;
    logic [19:0] w_cnt_sum;
    logic [28:0] w_sx_fin;
    logic [28:0] w_sy_fin;
    logic [18:0] w_cnt_fin;
    logic        w_sat_fin;
    logic        w_accept;

    logic [19:0] w_rx_sh;
    logic [19:0] w_ry_sh;
    logic        w_rx_ge;
    logic        w_ry_ge;
    logic [18:0] w_rx_nxt;
    logic [18:0] w_ry_nxt;
    logic [28:0] w_qx_nxt;
    logic [28:0] w_qy_nxt;
    logic [9:0]  w_x_clamp;
    logic [8:0]  w_y_clamp;

    // Final frame values include a match pixel arriving in the frame-end cycle.
    assign w_hit     = iPix_Val & iMatch;
    assign w_sx_sum  = {1'b0, r_sum_x} + {20'd0, iX};
    assign w_sy_sum  = {1'b0, r_sum_y} + {21'd0, iY};
    assign w_cnt_sum = {1'b0, r_cnt} + 20'd1;

    assign w_sx_fin  = !w_hit ? r_sum_x : (w_sx_sum[29] ? '1 : w_sx_sum[28:0]);
    assign w_sy_fin  = !w_hit ? r_sum_y : (w_sy_sum[29] ? '1 : w_sy_sum[28:0]);
    assign w_cnt_fin = !w_hit ? r_cnt   : (w_cnt_sum[19] ? '1 : w_cnt_sum[18:0]);
    assign w_sat_fin = r_sat | (w_hit & (w_sx_sum[29] | w_sy_sum[29] | w_cnt_sum[19]));

    assign w_accept  = (r_state == StIdle) && iFrame_End && (w_cnt_fin >= MinCnt) && !w_sat_fin;

    // Restoring step: partial remainder is always below the divisor, so 19 bits hold it.
    assign w_rx_sh  = {r_rx, r_qx[28]};
    assign w_ry_sh  = {r_ry, r_qy[28]};
    assign w_rx_ge  = w_rx_sh >= {1'b0, r_div};
    assign w_ry_ge  = w_ry_sh >= {1'b0, r_div};
    assign w_rx_nxt = w_rx_ge ? (w_rx_sh[18:0] - r_div) : w_rx_sh[18:0];
    assign w_ry_nxt = w_ry_ge ? (w_ry_sh[18:0] - r_div) : w_ry_sh[18:0];
    assign w_qx_nxt = {r_qx[27:0], w_rx_ge};
    assign w_qy_nxt = {r_qy[27:0], w_ry_ge};

    assign w_x_clamp = (w_qx_nxt > XMax) ? XMax[9:0] : w_qx_nxt[9:0];
    assign w_y_clamp = (w_qy_nxt > YMax) ? YMax[8:0] : w_qy_nxt[8:0];

    always_ff @(posedge clk) begin
        if (rst || iFrame_End) begin
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_sum_x <= w_sx_fin;
            r_sum_y <= w_sy_fin;
            r_cnt   <= w_cnt_fin;
            r_sat   <= w_sat_fin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div    <= '0;
            r_qx     <= '0;
            r_qy     <= '0;
            r_rx     <= '0;
            r_ry     <= '0;
            r_step   <= '0;
            r_x_cent <= 10'd320;
            r_y_cent <= 9'd240;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= iFrame_End & !w_accept;
            if (w_accept) begin
                r_div  <= w_cnt_fin;
                r_qx   <= w_sx_fin;
                r_qy   <= w_sy_fin;
                r_rx   <= '0;
                r_ry   <= '0;
                r_step <= '0;
            end else if (r_state == StDiv) begin
                r_qx   <= w_qx_nxt;
                r_qy   <= w_qy_nxt;
                r_rx   <= w_rx_nxt;
                r_ry   <= w_ry_nxt;
                r_step <= r_step + 5'd1;
                if (r_step == 5'd28) begin
                    r_x_cent <= w_x_clamp;
                    r_y_cent <= w_y_clamp;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_nxt = StDiv;
            StDiv:   if (r_step == 5'd28) w_state_nxt = StOut;
            StOut:   w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    assign oCent_Val = (r_state == StOut);
    assign oBusy     = (r_state != StIdle);
    assign oDrop     = r_drop;
    assign oX_Cent   = r_x_cent;
    assign oY_Cent   = r_y_cent;

endmodule
